fract_mul_seq: RTL

FRACT_MUL_SEQ -- requirements
Module: fract_mul_seq

---
 rtl/mbm_pkg.sv | 17 +
 rtl/fract_add7.sv | 27 ++
 rtl/fract_mul_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mbm_pkg.sv
// Shared constants and FSM state type for the sequential fractional multiplier.
package mbm_pkg;

    localparam int FRACT_W = 7;
    localparam int PROD_W  = 14;

    // Index of the final RUN iteration (7 iterations: 0..6).
    localparam logic [2:0] ITER_LAST = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fract_add7.sv
// 7-bit ripple-carry adder with carry in/out; purely combinational.
module fract_add7
    import mbm_pkg::*;
(
    input  logic [FRACT_W-1:0] i_a,
    input  logic [FRACT_W-1:0] i_b,
    input  logic               i_cin,
    output logic [FRACT_W-1:0] o_sum,
    output logic               o_cout
);

    logic [FRACT_W:0] w_carry;

    // Ripple the carry bit by bit from i_cin up to the carry out.
    always_comb begin
        w_carry    = {(FRACT_W+1){1'b0}};
        o_sum      = {FRACT_W{1'b0}};
        w_carry[0] = i_cin;
        for (int k = 0; k < FRACT_W; k++) begin
            o_sum[k]     = i_a[k] ^ i_b[k] ^ w_carry[k];
            w_carry[k+1] = (i_a[k] & i_b[k]) | (w_carry[k] & (i_a[k] ^ i_b[k]));
        end
    end

    assign o_cout = w_carry[FRACT_W];

endmodule

// File: rtl/fract_mul_seq.sv
// Sequential shift-add multiplier of two unsigned Q0.7 fractions.
// Optional feature macro: MBM_BIAS_COMP_EN adds a ROUND state that rounds
// the reduced Q0.7 result half-up instead of truncating it.
module fract_mul_seq
    import mbm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRACT_W-1:0] a,
    input  logic [FRACT_W-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [PROD_W-1:0]  p_full,
    output logic [FRACT_W-1:0] p_trunc
);

    state_t               r_state;
    state_t               w_next_state;

    logic [FRACT_W-1:0]   r_mcand;
    logic [FRACT_W-1:0]   r_mplier;
    logic [FRACT_W-1:0]   r_acc;
    logic [2:0]           r_cnt;
`ifdef MBM_BIAS_COMP_EN
    logic [FRACT_W-1:0]   r_rnd;
`endif

    logic                 r_busy;
    logic                 r_done;
    logic [PROD_W-1:0]    r_p_full;
    logic [FRACT_W-1:0]   r_p_trunc;

    logic                 w_load;
    logic                 w_shift;
    logic                 w_round_we;
    logic                 w_capture;
    logic [FRACT_W-1:0]   w_add_a;
    logic [FRACT_W-1:0]   w_add_b;
    logic                 w_add_cin;
    logic [FRACT_W-1:0]   w_sum;
    logic                 w_cout;

    // The single adder, shared between partial-product accumulation and rounding.
    fract_add7 u_add (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == ITER_LAST) begin
`ifdef MBM_BIAS_COMP_EN
                    w_next_state = ST_ROUND;
`else
                    w_next_state = ST_DONE;
`endif
                end else begin
                    w_next_state = ST_RUN;
                end
            end
`ifdef MBM_BIAS_COMP_EN
            ST_ROUND: w_next_state = ST_DONE;
`endif
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Per-state datapath controls and adder operand muxing.
    always_comb begin
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_round_we = 1'b0;
        w_capture  = 1'b0;
        w_add_a    = {FRACT_W{1'b0}};
        w_add_b    = {FRACT_W{1'b0}};
        w_add_cin  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = start;
            end
            ST_RUN: begin
                w_shift = 1'b1;
                w_add_a = r_acc;
                if (r_mplier[0]) begin
                    w_add_b = r_mcand;
                end else begin
                    w_add_b = {FRACT_W{1'b0}};
                end
            end
`ifdef MBM_BIAS_COMP_EN
            ST_ROUND: begin
                // acc is p_full[13:7] and mplier[6] is p_full[6] here.
                w_round_we = 1'b1;
                w_add_a    = r_acc;
                w_add_cin  = r_mplier[6];
            end
`endif
            ST_DONE: begin
                w_capture = 1'b1;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Operand capture and shift-add iteration; after 7 shifts {acc,mplier} = a*b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= {FRACT_W{1'b0}};
            r_mplier <= {FRACT_W{1'b0}};
            r_acc    <= {FRACT_W{1'b0}};
            r_cnt    <= 3'd0;
        end else if (w_load) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= {FRACT_W{1'b0}};
            r_cnt    <= 3'd0;
        end else if (w_shift) begin
            {r_acc, r_mplier} <= {w_cout, w_sum, r_mplier[FRACT_W-1:1]};
            r_cnt             <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

`ifdef MBM_BIAS_COMP_EN
    // Rounded high half; the ROUND carry out can never be set (max 126 + 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rnd <= {FRACT_W{1'b0}};
        end else if (w_round_we) begin
            r_rnd <= w_sum;
        end else begin
            r_rnd <= r_rnd;
        end
    end
`endif

    // Registered outputs: results latch on leaving DONE and hold until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p_full  <= {PROD_W{1'b0}};
            r_p_trunc <= {FRACT_W{1'b0}};
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= w_capture;
            if (w_capture) begin
                r_p_full <= {r_acc, r_mplier};
`ifdef MBM_BIAS_COMP_EN
                r_p_trunc <= r_rnd;
`else
                r_p_trunc <= r_acc;
`endif
            end else begin
                r_p_full  <= r_p_full;
                r_p_trunc <= r_p_trunc;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign p_full  = r_p_full;
    assign p_trunc = r_p_trunc;

endmodule
